// File: rtl/spi_slave_pkg.sv
// Shared command codes and FSM state encoding for the SPI frame slave.
// No logic; imported by the slave top.
package spi_slave_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Gray sequence along the normal IDLE -> RX -> WAIT_TX -> TX -> DONE path.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_RX      = 3'b001,
    ST_WAIT_TX = 3'b011,
    ST_TX      = 3'b010,
    ST_DONE    = 3'b110
  } state_t;

endpackage

// File: rtl/spi_slave_frame_p_if.sv
// Frame/RAM-side bundle of the SPI slave; slave modport is the DUT view.
// Pure wiring, no latency, no backpressure.
interface spi_slave_frame_p_if #(
  parameter int DATA_W = 8
);
  logic              ss_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              seq_err;
  logic              tx_timeout;
  logic              frame_abort;

  modport slave (
    input  ss_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, seq_err, tx_timeout, frame_abort
  );

  modport master (
    output ss_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, seq_err, tx_timeout, frame_abort
  );
endinterface

// File: rtl/spi_shift_p.sv
// Generic shift register: parallel load has priority over a one-bit shift.
// One cycle per load/shift; no backpressure.
module spi_shift_p #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q
);

  logic [W-1:0] q_nxt;

  assign q_nxt = MSB_FIRST ? {q[W-2:0], sin} : {sin, q[W-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_dat;
    end else if (shift) begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/spi_slave_frame_p.sv
// SPI slave: deserialises DATA_W+2 bit command frames, serialises RAM read data on MISO.
// rx_valid the cycle after the last frame bit; MISO first bit the cycle after tx_valid; ss_n high aborts.
module spi_slave_frame_p
  import spi_slave_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int TX_TIMEOUT = 16,
  parameter int TO_W       = 5
) (
  input logic              clk,
  input logic              rst_n,
  spi_slave_frame_p_if.slave bus
);

  localparam int W     = DATA_W + 2;
  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TX_TIMEOUT > 0) ? TX_TIMEOUT - 1 : 0);
  localparam logic [DATA_W-1:0] TX_MARK = MSB_FIRST ? {1'b1, {(DATA_W-1){1'b0}}}
                                                    : {{(DATA_W-1){1'b0}}, 1'b1};

  (* fsm_encoding = "gray" *) state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             rd_pend_q, rd_pend_d;
  logic [W-2:0]     rx_q;
  logic [DATA_W:0]  tx_q;
  logic [DATA_W:0]  tx_ld_dat;
  logic [W-1:0]     frame;
  logic [1:0]       frame_cmd;
  logic             tx_last;
  logic rx_shift, rx_fin, tx_load, tx_shift, tx_clr, abort_hit, tmo_hit, seq_hit;

  // The RX shifter only holds the first W-1 bits; the live MOSI bit completes the frame.
  assign frame     = MSB_FIRST ? {rx_q, bus.MOSI} : {bus.MOSI, rx_q};
  assign frame_cmd = frame[W-1:W-2];

  // TX shifter carries a trailing marker bit: the frame is over once only the
  // marker remains behind the bit currently on MISO.
  assign tx_ld_dat = tx_clr ? '0 : (MSB_FIRST ? {bus.tx_data, 1'b1} : {1'b1, bus.tx_data});
  assign tx_last   = MSB_FIRST ? (tx_q[DATA_W-1:0] == TX_MARK) : (tx_q[DATA_W:1] == TX_MARK);
  assign bus.MISO  = MSB_FIRST ? tx_q[DATA_W] : tx_q[0];

  spi_shift_p #(.W(W-1), .MSB_FIRST(MSB_FIRST)) u_rx_shift (
    .clk(clk), .rst_n(rst_n), .load(1'b0), .load_dat('0),
    .shift(rx_shift), .sin(bus.MOSI), .q(rx_q)
  );

  spi_shift_p #(.W(DATA_W+1), .MSB_FIRST(MSB_FIRST)) u_tx_shift (
    .clk(clk), .rst_n(rst_n), .load(tx_load | tx_clr), .load_dat(tx_ld_dat),
    .shift(tx_shift), .sin(1'b0), .q(tx_q)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    rd_pend_d = rd_pend_q;
    rx_shift  = 1'b0;
    rx_fin    = 1'b0;
    tx_load   = 1'b0;
    tx_shift  = 1'b0;
    tx_clr    = 1'b0;
    abort_hit = 1'b0;
    tmo_hit   = 1'b0;
    seq_hit   = 1'b0;
    if (state_q != ST_IDLE && bus.ss_n) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      to_d      = '0;
      tx_clr    = 1'b1;
      abort_hit = (state_q != ST_DONE);
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = CNT_FULL;
          to_d  = '0;
          if (!bus.ss_n) state_d = ST_RX;
        end
        ST_RX: begin
          rx_shift = 1'b1;
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            rx_fin = 1'b1;
            if (frame_cmd == CMD_RD_ADDR)      rd_pend_d = 1'b1;
            else if (frame_cmd == CMD_RD_DATA) rd_pend_d = 1'b0;
            seq_hit = (frame_cmd == CMD_RD_DATA) && !rd_pend_q;
            state_d = (frame_cmd == CMD_RD_DATA && rd_pend_q) ? ST_WAIT_TX : ST_DONE;
          end
        end
        ST_WAIT_TX: begin
          to_d = to_q + 1'b1;
          if (bus.tx_valid) begin
            tx_load = 1'b1;
            state_d = ST_TX;
          end else if (TX_TIMEOUT > 0 && to_q == TO_LAST) begin
            tmo_hit = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_TX: begin
          if (tx_last) begin
            tx_clr  = 1'b1;
            state_d = ST_DONE;
          end else begin
            tx_shift = 1'b1;
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      to_q            <= '0;
      rd_pend_q       <= 1'b0;
      bus.rx_data     <= '0;
      bus.rx_valid    <= 1'b0;
      bus.seq_err     <= 1'b0;
      bus.tx_timeout  <= 1'b0;
      bus.frame_abort <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      to_q            <= to_d;
      rd_pend_q       <= rd_pend_d;
      bus.rx_valid    <= rx_fin;
      bus.seq_err     <= seq_hit;
      bus.tx_timeout  <= tmo_hit;
      bus.frame_abort <= abort_hit;
      if (rx_fin) bus.rx_data <= frame;
    end
  end

endmodule

// File: tb/tb_spi_slave_frame_p.sv
// Bench for spi_slave_frame_p: MSB-first/timeout instance with scoreboard, plus LSB-first/no-timeout instance.
module tb_spi_slave_frame_p;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_frame_p_if #(.DATA_W(8)) ia ();
  spi_slave_frame_p_if #(.DATA_W(8)) ib ();

  spi_slave_frame_p #(.DATA_W(8), .MSB_FIRST(1'b1), .TX_TIMEOUT(4), .TO_W(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );
  spi_slave_frame_p #(.DATA_W(8), .MSB_FIRST(1'b0), .TX_TIMEOUT(0), .TO_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );

  typedef struct packed {
    logic       seq;
    logic [9:0] dat;
  } rx_exp_t;

  rx_exp_t rx_q[$];
  int      ev_q[$];   // 1 = frame_abort, 2 = tx_timeout
  rx_exp_t mon_e;
  int      mon_ev;
  logic    tx_win_a = 1'b0;
  logic    tx_win_b = 1'b0;
  int      vectors = 0;
  int      miscompares = 0;
  logic [7:0] got;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard for instance A: every output event must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ia.rx_valid) begin
        check_eq("rx_expected", rx_q.size() > 0, 1);
        if (rx_q.size() > 0) begin
          mon_e = rx_q.pop_front();
          check_eq("rx_data", ia.rx_data, mon_e.dat);
          check_eq("seq_err", ia.seq_err, mon_e.seq);
        end
      end
      if (ia.seq_err) check_eq("seq_err_with_rxv", ia.rx_valid, 1);
      if (ia.frame_abort || ia.tx_timeout) begin
        check_eq("ev_expected", ev_q.size() > 0, 1);
        if (ev_q.size() > 0) begin
          mon_ev = ev_q.pop_front();
          check_eq("ev_kind", {ia.tx_timeout, ia.frame_abort}, mon_ev);
        end
      end
      if (!tx_win_a && ia.MISO !== 1'b0) check_eq("a_miso_quiet", ia.MISO, 0);
      if (!tx_win_b && ib.MISO !== 1'b0) check_eq("b_miso_quiet", ib.MISO, 0);
      if ((ib.frame_abort | ib.tx_timeout | ib.seq_err) !== 1'b0)
        check_eq("b_no_pulse", {ib.frame_abort, ib.tx_timeout, ib.seq_err}, 0);
    end
  end

  task automatic shift_a(input logic [9:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ia.MOSI = f[9-i];
    end
  endtask

  task automatic frame_a(input logic [9:0] f);
    @(negedge clk);
    ia.ss_n = 1'b0;
    shift_a(f, 10);
    @(negedge clk);
    check_eq("a_rxv_timing", ia.rx_valid, 1);
  endtask

  task automatic end_a();
    @(negedge clk);
    ia.ss_n = 1'b1;
    ia.MOSI = 1'b0;
    @(negedge clk);
  endtask

  task automatic frame_b(input logic [9:0] f);
    @(negedge clk);
    ib.ss_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ib.MOSI = f[i];
    end
    @(negedge clk);
    check_eq("b_rxv", ib.rx_valid, 1);
    check_eq("b_rx_data", ib.rx_data, f);
  endtask

  task automatic end_b();
    @(negedge clk);
    ib.ss_n = 1'b1;
    ib.MOSI = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    ia.ss_n = 1'b1; ia.MOSI = 1'b0; ia.tx_data = '0; ia.tx_valid = 1'b0;
    ib.ss_n = 1'b1; ib.MOSI = 1'b0; ib.tx_data = '0; ib.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_miso", ia.MISO, 0);
    check_eq("rst_rx_data", ia.rx_data, 0);
    check_eq("rst_rx_valid", ia.rx_valid, 0);
    check_eq("rst_pulses", {ia.seq_err, ia.tx_timeout, ia.frame_abort}, 0);
    check_eq("rst_b", {ib.MISO, ib.rx_valid, ib.rx_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write address
    rx_q.push_back({1'b0, 10'h0A5});
    frame_a(10'h0A5);
    end_a();

    // Read address then read data, tx_valid three WAIT_TX cycles in
    rx_q.push_back({1'b0, 10'h203});
    frame_a(10'h203);
    end_a();
    rx_q.push_back({1'b0, 10'h300});
    frame_a(10'h300);
    repeat (2) @(negedge clk);
    ia.tx_valid = 1'b1; ia.tx_data = 8'hC3; tx_win_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ia.tx_valid = 1'b0;
      got[7-i] = ia.MISO;
    end
    check_eq("a_tx_byte", got, 8'hC3);
    @(negedge clk);
    check_eq("a_tx_tail", ia.MISO, 0);
    tx_win_a = 1'b0;
    end_a();

    // rd_pending is now clear: another read-data frame is a sequence error
    rx_q.push_back({1'b1, 10'h300});
    frame_a(10'h300);
    repeat (4) @(negedge clk);
    end_a();

    // Sequence error straight after reset, then linger in DONE
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rx_q.push_back({1'b1, 10'h35A});
    frame_a(10'h35A);
    repeat (6) @(negedge clk);
    end_a();

    // Timeout on the 4th WAIT_TX edge
    rx_q.push_back({1'b0, 10'h280});
    frame_a(10'h280);
    end_a();
    rx_q.push_back({1'b0, 10'h3FF});
    frame_a(10'h3FF);
    ev_q.push_back(2);
    repeat (3) @(negedge clk);
    check_eq("tmo_early", ia.tx_timeout, 0);
    @(negedge clk);
    check_eq("tmo_at_4", ia.tx_timeout, 1);
    end_a();

    // Abort after 6 bits, then a clean frame
    @(negedge clk);
    ia.ss_n = 1'b0;
    shift_a(10'h1C7, 6);
    @(negedge clk);
    ia.ss_n = 1'b1;
    ev_q.push_back(1);
    @(negedge clk);
    check_eq("abort6_pulse", ia.frame_abort, 1);
    check_eq("abort6_keep", ia.rx_data, 10'h3FF);
    @(negedge clk);
    rx_q.push_back({1'b0, 10'h1F0});
    frame_a(10'h1F0);
    end_a();

    // ss_n rises on the edge that samples the final bit: abort wins
    @(negedge clk);
    ia.ss_n = 1'b0;
    shift_a(10'h2AA, 9);
    @(negedge clk);
    ia.MOSI = 1'b0;
    ia.ss_n = 1'b1;
    ev_q.push_back(1);
    @(negedge clk);
    check_eq("abort10_pulse", ia.frame_abort, 1);
    check_eq("abort10_no_rxv", ia.rx_valid, 0);
    check_eq("abort10_keep", ia.rx_data, 10'h1F0);
    @(negedge clk);

    // Abort while waiting for tx_valid
    rx_q.push_back({1'b0, 10'h2C0});
    frame_a(10'h2C0);
    end_a();
    rx_q.push_back({1'b0, 10'h3C0});
    frame_a(10'h3C0);
    ia.ss_n = 1'b1;
    ev_q.push_back(1);
    @(negedge clk);
    check_eq("abort_wait_pulse", ia.frame_abort, 1);
    @(negedge clk);

    // LSB-first instance, unbounded wait for tx_valid
    frame_b(10'h203);
    end_b();
    frame_b(10'h300);
    repeat (20) @(negedge clk);
    ib.tx_valid = 1'b1; ib.tx_data = 8'h01; tx_win_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ib.tx_valid = 1'b0;
      got[i] = ib.MISO;
      if (i == 0) check_eq("b_first_bit", ib.MISO, 1);
    end
    check_eq("b_tx_byte", got, 8'h01);
    @(negedge clk);
    check_eq("b_tx_tail", ib.MISO, 0);
    tx_win_b = 1'b0;
    end_b();

    // Reset in the middle of TX
    frame_b(10'h203);
    end_b();
    frame_b(10'h300);
    ib.tx_valid = 1'b1; ib.tx_data = 8'hFF; tx_win_b = 1'b1;
    @(negedge clk);
    ib.tx_valid = 1'b0;
    check_eq("b_midtx_bit0", ib.MISO, 1);
    @(negedge clk);
    check_eq("b_midtx_bit1", ib.MISO, 1);
    rst_n = 1'b0;
    ib.ss_n = 1'b1;
    @(negedge clk);
    check_eq("b_rst_outs", {ib.MISO, ib.rx_valid, ib.rx_data}, 0);
    check_eq("b_rst_pulses", {ib.seq_err, ib.tx_timeout, ib.frame_abort}, 0);
    tx_win_b = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    check_eq("sb_rx_drained", rx_q.size(), 0);
    check_eq("sb_ev_drained", ev_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
